// File: rtl/cclimb_pkg.sv
// rtl/cclimb_pkg.sv - shared region map, region/FSM enums and helpers for the crazy_climber ROM loader
package cclimb_pkg;

    typedef enum logic [2:0] {
        REG_CPU,
        REG_TILE,
        REG_BIGSPR,
        REG_SAMPLE,
        REG_PROM,
        REG_NONE
    } region_t;

    localparam logic [15:0] CPU_BASE    = 16'h0000;
    localparam logic [15:0] CPU_SIZE    = 16'h6000;
    localparam logic [15:0] TILE_BASE   = 16'h6000;
    localparam logic [15:0] TILE_SIZE   = 16'h2000;
    localparam logic [15:0] BIGSPR_BASE = 16'h8000;
    localparam logic [15:0] BIGSPR_SIZE = 16'h0800;
    localparam logic [15:0] SAMPLE_BASE = 16'h8800;
    localparam logic [15:0] SAMPLE_SIZE = 16'h2000;
    localparam logic [15:0] PROM_BASE   = 16'hA800;
    localparam logic [15:0] PROM_SIZE   = 16'h0080;
    localparam logic [16:0] IMAGE_BYTES = 17'h0A880;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_SETTLE,
        ST_READY
    } state_t;

    function automatic logic [4:0] region_onehot(input region_t r);
        case (r)
            REG_CPU:    return 5'b00001;
            REG_TILE:   return 5'b00010;
            REG_BIGSPR: return 5'b00100;
            REG_SAMPLE: return 5'b01000;
            REG_PROM:   return 5'b10000;
            default:    return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/cclimb_rom_decode.sv
// rtl/cclimb_rom_decode.sv - combinational flat image address to region/relative address decoder
module cclimb_rom_decode
    import cclimb_pkg::*;
(
    input  logic [24:0] addr,
    output region_t     region,
    output logic [15:0] rel_addr,
    output logic        valid
);

    logic [15:0] low;
    assign low = addr[15:0];

    always_comb begin
        region   = REG_NONE;
        rel_addr = 16'h0000;
        valid    = 1'b0;
        if (addr[24:16] == 9'd0) begin
            valid = 1'b1;
            if (low < CPU_BASE + CPU_SIZE) begin
                region   = REG_CPU;
                rel_addr = low - CPU_BASE;
            end else if (low < TILE_BASE + TILE_SIZE) begin
                region   = REG_TILE;
                rel_addr = low - TILE_BASE;
            end else if (low < BIGSPR_BASE + BIGSPR_SIZE) begin
                region   = REG_BIGSPR;
                rel_addr = low - BIGSPR_BASE;
            end else if (low < SAMPLE_BASE + SAMPLE_SIZE) begin
                region   = REG_SAMPLE;
                rel_addr = low - SAMPLE_BASE;
            end else if (low < PROM_BASE + PROM_SIZE) begin
                region   = REG_PROM;
                rel_addr = low - PROM_BASE;
            end else begin
                valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cclimb_rom_loader.sv
// rtl/cclimb_rom_loader.sv - ioctl to crazy_climber dn_* loader; CCLIMB_ROM_CHECKSUM_EN adds byte-sum check and sum_out
module cclimb_rom_loader
    import cclimb_pkg::*;
#(
    parameter logic [16:0] TOTAL_BYTES   = IMAGE_BYTES,
    parameter int          SETTLE_CYCLES = 1024,
    parameter logic [7:0]  ROM_INDEX     = 8'd0,
    parameter logic [15:0] EXPECTED_SUM  = 16'h0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [4:0]  dn_sel,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        load_err,
    output logic [16:0] byte_count
`ifdef CCLIMB_ROM_CHECKSUM_EN
    ,
    output logic [15:0] sum_out
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state, state_nx;
    logic               dl_q;
    logic [CNT_W-1:0]   settle_cnt;
    region_t            dec_region;
    logic [15:0]        dec_addr;
    logic               dec_valid;
    logic               sum_ok;

    cclimb_rom_decode u_decode (
        .addr     (ioctl_addr),
        .region   (dec_region),
        .rel_addr (dec_addr),
        .valid    (dec_valid)
    );

    logic index_ok, start, wr_live, accept, stray, dl_end, image_ok, load_entry;
    assign index_ok   = (ioctl_index == ROM_INDEX);
    assign start      = ioctl_download & ~dl_q & index_ok;
    assign wr_live    = (state == ST_LOADING) & ioctl_wr & ioctl_download & index_ok;
    assign accept     = wr_live & dec_valid;
    assign stray      = wr_live & ~dec_valid;
    assign dl_end     = (state == ST_LOADING) & ~ioctl_download;
    assign image_ok   = (byte_count == TOTAL_BYTES) & ~load_err & sum_ok;
    assign load_entry = (state != ST_LOADING) & (state_nx == ST_LOADING);

    always_comb begin
        state_nx   = state;
        core_reset = 1'b1;
        rom_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_LOADING;
            end
            ST_LOADING: begin
                if (dl_end) state_nx = image_ok ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                if (start)
                    state_nx = ST_LOADING;
                else if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1))
                    state_nx = ST_READY;
            end
            ST_READY: begin
                core_reset = 1'b0;
                rom_ready  = 1'b1;
                if (start) state_nx = ST_LOADING;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            dl_q       <= 1'b0;
            settle_cnt <= '0;
            dn_addr    <= 16'h0000;
            dn_data    <= 8'h00;
            dn_wr      <= 1'b0;
            dn_sel     <= 5'b00000;
            load_err   <= 1'b0;
            byte_count <= 17'd0;
        end else begin
            state   <= state_nx;
            dl_q    <= ioctl_download;
            dn_wr   <= accept;
            dn_sel  <= accept ? region_onehot(dec_region) : 5'b00000;
            if (accept) begin
                dn_addr <= dec_addr;
                dn_data <= ioctl_dout;
            end
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (load_entry) begin
                byte_count <= 17'd0;
                load_err   <= 1'b0;
            end else begin
                // Duplicate addresses count again; the counter only stops at all-ones.
                if (accept && byte_count != 17'h1FFFF)
                    byte_count <= byte_count + 17'd1;
                if (stray || (dl_end && !image_ok))
                    load_err <= 1'b1;
            end
        end
    end

`ifdef CCLIMB_ROM_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            sum <= 16'h0000;
        else if (load_entry)
            sum <= 16'h0000;
        else if (accept)
            sum <= sum + {8'h00, ioctl_dout};
    end

    assign sum_out = sum;
    assign sum_ok  = (sum == EXPECTED_SUM);
`else
    logic unused_expected_sum;
    assign unused_expected_sum = ^EXPECTED_SUM;
    assign sum_ok              = 1'b1;
`endif

endmodule

// File: tb/tb_cclimb_rom_loader.sv
// tb/tb_cclimb_rom_loader.sv - self-checking bench for cclimb_rom_loader
module tb_cclimb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [4:0]  dn_sel;
    logic        core_reset, rom_ready, load_err;
    logic [16:0] byte_count;

    // Image byte at a is a[7:0]^0x5A; its 16-bit sum over 0..0xA87F is 0xCBC0.
    localparam logic [15:0] IMG_SUM = 16'hCBC0;
`ifdef CCLIMB_ROM_CHECKSUM_EN
    logic [15:0] sum_out;
    localparam int SHORT_LEN = 32'h500;
`else
    localparam int SHORT_LEN = 32'h5000;
`endif

    cclimb_rom_loader #(
        .TOTAL_BYTES   (17'h0A880),
        .SETTLE_CYCLES (1024),
        .ROM_INDEX     (8'd0),
        .EXPECTED_SUM  (IMG_SUM)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_sel         (dn_sel),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .load_err       (load_err),
        .byte_count     (byte_count)
`ifdef CCLIMB_ROM_CHECKSUM_EN
        ,
        .sum_out        (sum_out)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic [4:0]  sel;
        logic [15:0] rel;
        logic [7:0]  data;
        logic [24:0] src;
    } exp_t;
    exp_t q[$];

    int          pulses = 0;
    int          mon_err = 0;
    logic        seen6000 = 1'b0;
    logic [4:0]  sel6000 = 5'd0;
    logic [15:0] addr6000 = 16'hFFFF;

    // Every dn_wr must match the oldest expected write, on exactly its due cycle.
    always @(negedge clk_sys) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            mon_err++;
            q.delete(0);
        end
        if (dn_wr === 1'b1) begin
            pulses++;
            if (q.size() == 0 || q[0].due != cyc)
                mon_err++;
            else begin
                if (dn_sel !== q[0].sel || dn_addr !== q[0].rel || dn_data !== q[0].data)
                    mon_err++;
                if (q[0].src == 25'h0006000) begin
                    seen6000 = 1'b1;
                    sel6000  = dn_sel;
                    addr6000 = dn_addr;
                end
                q.delete(0);
            end
        end else if (dn_sel !== 5'b00000) begin
            mon_err++;
        end
    end

    function automatic void exp_map(input logic [24:0] a, output logic [4:0] sel, output logic [15:0] rel);
        logic [15:0] lo;
        lo = a[15:0];
        if (a < 25'h0006000)      begin sel = 5'b00001; rel = lo; end
        else if (a < 25'h0008000) begin sel = 5'b00010; rel = lo - 16'h6000; end
        else if (a < 25'h0008800) begin sel = 5'b00100; rel = lo - 16'h8000; end
        else if (a < 25'h000A800) begin sel = 5'b01000; rel = lo - 16'h8800; end
        else if (a < 25'h000A880) begin sel = 5'b10000; rel = lo - 16'hA800; end
        else                      begin sel = 5'b00000; rel = 16'h0000; end
    endfunction

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic push,
                             input logic [4:0] sel, input logic [15:0] rel);
        exp_t e;
        @(posedge clk_sys);
        #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (push) begin
            e.due = cyc + 1; e.sel = sel; e.rel = rel; e.data = d; e.src = a;
            q.push_back(e);
        end
    endtask

    task automatic send_image(input int n, input logic [7:0] bump);
        logic [24:0] a;
        logic [7:0]  d;
        logic [4:0]  sel;
        logic [15:0] rel;
        for (int i = 0; i < n; i++) begin
            a = 25'(i);
            d = a[7:0] ^ 8'h5A;
            if (i == 0) d = d + bump;
            exp_map(a, sel, rel);
            send_byte(a, d, 1'b1, sel, rel);
        end
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b1;
        ioctl_index    = idx;
    endtask

    task automatic dl_stop();
        @(posedge clk_sys);
        #1;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic [4:0]  sel;
        logic [15:0] daddr;
        logic [7:0]  ddata;
        logic [16:0] cnt;
        logic        err;
    } vec_t;
    vec_t vt[13];

    int p0, e0, k;

    initial begin
        vt[0]  = '{25'h0000000, 8'h11, 1'b1, 5'b00001, 16'h0000, 8'h11, 17'd1,  1'b0};
        vt[1]  = '{25'h0005FFF, 8'h22, 1'b1, 5'b00001, 16'h5FFF, 8'h22, 17'd2,  1'b0};
        vt[2]  = '{25'h0006000, 8'h33, 1'b1, 5'b00010, 16'h0000, 8'h33, 17'd3,  1'b0};
        vt[3]  = '{25'h0007FFF, 8'h44, 1'b1, 5'b00010, 16'h1FFF, 8'h44, 17'd4,  1'b0};
        vt[4]  = '{25'h0008000, 8'h55, 1'b1, 5'b00100, 16'h0000, 8'h55, 17'd5,  1'b0};
        vt[5]  = '{25'h00087FF, 8'h66, 1'b1, 5'b00100, 16'h07FF, 8'h66, 17'd6,  1'b0};
        vt[6]  = '{25'h0008800, 8'h77, 1'b1, 5'b01000, 16'h0000, 8'h77, 17'd7,  1'b0};
        vt[7]  = '{25'h000A7FF, 8'h88, 1'b1, 5'b01000, 16'h1FFF, 8'h88, 17'd8,  1'b0};
        vt[8]  = '{25'h000A800, 8'h99, 1'b1, 5'b10000, 16'h0000, 8'h99, 17'd9,  1'b0};
        vt[9]  = '{25'h000A87F, 8'hAA, 1'b1, 5'b10000, 16'h007F, 8'hAA, 17'd10, 1'b0};
        vt[10] = '{25'h000A880, 8'hBB, 1'b0, 5'b00000, 16'h007F, 8'hAA, 17'd10, 1'b1};
        vt[11] = '{25'h0010000, 8'hCC, 1'b0, 5'b00000, 16'h007F, 8'hAA, 17'd10, 1'b1};
        vt[12] = '{25'h1FF0000, 8'hDD, 1'b0, 5'b00000, 16'h007F, 8'hAA, 17'd10, 1'b1};

        #1 reset = 1'b1;
        #2;
        check("rst_dn_addr", dn_addr, 0);
        check("rst_dn_data", dn_data, 0);
        check("rst_dn_wr", dn_wr, 0);
        check("rst_dn_sel", dn_sel, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_rom_ready", rom_ready, 0);
        check("rst_load_err", load_err, 0);
        check("rst_byte_count", byte_count, 0);
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;

        // Region boundaries and stray addresses, one write at a time.
        e0 = mon_err;
        dl_start(8'd0);
        foreach (vt[i]) begin
            send_byte(vt[i].addr, vt[i].data, vt[i].wr, vt[i].sel, vt[i].daddr);
            @(posedge clk_sys);
            #1;
            ioctl_wr = 1'b0;
            check($sformatf("vec%0d_dn_wr", i), dn_wr, vt[i].wr);
            check($sformatf("vec%0d_dn_sel", i), dn_sel, vt[i].sel);
            check($sformatf("vec%0d_dn_addr", i), dn_addr, vt[i].daddr);
            check($sformatf("vec%0d_dn_data", i), dn_data, vt[i].ddata);
            check($sformatf("vec%0d_byte_count", i), byte_count, vt[i].cnt);
            check($sformatf("vec%0d_load_err", i), load_err, vt[i].err);
            @(posedge clk_sys);
            #1;
            check($sformatf("vec%0d_wr_one_cycle", i), dn_wr, 0);
            check($sformatf("vec%0d_addr_held", i), dn_addr, vt[i].daddr);
        end
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("vec_end_load_err", load_err, 1);
        check("vec_end_core_reset", core_reset, 1);
        check("vec_monitor", mon_err - e0, 0);

        // ioctl_wr with no download window is ignored.
        p0 = pulses;
        send_byte(25'h0000010, 8'h5A, 1'b0, 5'd0, 16'd0);
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        @(posedge clk_sys);
        #1;
        check("nowin_pulses", pulses - p0, 0);
        check("nowin_byte_count", byte_count, 10);

        // Zero-byte download: error cleared on entry, set again at the end.
        dl_start(8'd0);
        @(posedge clk_sys);
        #1;
        check("zero_entry_load_err", load_err, 0);
        check("zero_entry_byte_count", byte_count, 0);
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("zero_end_load_err", load_err, 1);

        // Short image.
        p0 = pulses; e0 = mon_err;
        dl_start(8'd0);
        send_image(SHORT_LEN, 8'd0);
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("short_load_err", load_err, 1);
        check("short_core_reset", core_reset, 1);
        check("short_rom_ready", rom_ready, 0);
        check("short_byte_count", byte_count, SHORT_LEN);
        check("short_pulses", pulses - p0, SHORT_LEN);
        check("short_monitor", mon_err - e0, 0);

        // Reset while a dn_wr is in flight.
        dl_start(8'd0);
        send_image(32'h1234, 8'd0);
        @(posedge clk_sys);
        #1;
        check("mid_inflight_wr", dn_wr, 1);
        e0 = mon_err;
        reset      = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0001234;
        q.delete();
        #1;
        check("mid_dn_wr", dn_wr, 0);
        check("mid_dn_sel", dn_sel, 0);
        check("mid_dn_addr", dn_addr, 0);
        check("mid_byte_count", byte_count, 0);
        @(posedge clk_sys);
        #1;
        check("mid_edge_dn_wr", dn_wr, 0);
        check("mid_edge_dn_data", dn_data, 0);
        check("mid_edge_core_reset", core_reset, 1);
        check("mid_edge_load_err", load_err, 0);
        check("mid_edge_byte_count", byte_count, 0);
        reset          = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;

        // Full image, back-to-back writes, then settle.
        p0 = pulses;
        dl_start(8'd0);
        send_image(32'hA880, 8'd0);
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("full_settle_core_reset", core_reset, 1);
        check("full_settle_rom_ready", rom_ready, 0);
        check("full_settle_load_err", load_err, 0);
        for (k = 1; k <= 2000; k++) begin
            @(posedge clk_sys);
            #1;
            if (rom_ready) break;
        end
        check("full_settle_cycles", k, 1024);
        check("full_core_reset", core_reset, 0);
        check("full_byte_count", byte_count, 17'h0A880);
        check("full_pulses", pulses - p0, 32'hA880);
        check("full_monitor", mon_err - e0, 0);
        check("full_seen6000", seen6000, 1);
        check("full_sel6000", sel6000, 5'b00010);
        check("full_addr6000", addr6000, 16'h0000);
`ifdef CCLIMB_ROM_CHECKSUM_EN
        check("full_sum_out", sum_out, IMG_SUM);
`endif

        // Non-matching index while READY is ignored.
        p0 = pulses;
        dl_start(8'd1);
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'hE0, 1'b0, 5'd0, 16'd0);
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("idx1_pulses", pulses - p0, 0);
        check("idx1_rom_ready", rom_ready, 1);
        check("idx1_core_reset", core_reset, 0);
        check("idx1_byte_count", byte_count, 17'h0A880);

        // Matching download from READY re-enters LOADING.
        dl_start(8'd0);
        @(posedge clk_sys);
        #1;
        check("reload_core_reset", core_reset, 1);
        check("reload_rom_ready", rom_ready, 0);
        check("reload_byte_count", byte_count, 0);
`ifdef CCLIMB_ROM_CHECKSUM_EN
        e0 = mon_err;
        send_image(32'hA880, 8'd1);
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("badsum_load_err", load_err, 1);
        check("badsum_core_reset", core_reset, 1);
        check("badsum_rom_ready", rom_ready, 0);
        check("badsum_byte_count", byte_count, 17'h0A880);
        check("badsum_sum_out", sum_out, IMG_SUM + 16'd1);
        check("badsum_monitor", mon_err - e0, 0);
`else
        dl_stop();
        @(posedge clk_sys);
        #1;
        check("reload_zero_load_err", load_err, 1);
        check("reload_zero_core_reset", core_reset, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
